// File: rtl/pio_input_debouncer.sv
// pio_input_debouncer: synchronise and debounce raw board inputs feeding the input PIO in_port
// Ports: clk; reset (async, active-high); raw_in (async board inputs); data_out (debounced level);
//        changed (one-cycle pulse when any data_out bit flips).
// Build option EDGE_CAPTURE_EN adds edge_clear (write-1-to-clear), edge_capture (sticky flips), irq.
module pio_input_debouncer #(
    parameter int               WIDTH          = 14,
    parameter int               TICK_DIV       = 50000,
    parameter int               DEBOUNCE_TICKS = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] data_out,
`ifdef EDGE_CAPTURE_EN
    output logic             changed,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
`else
    output logic             changed
`endif
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = DEBOUNCE_TICKS > 1 ? $clog2(DEBOUNCE_TICKS) : 1;
    logic [WIDTH-1:0]         s1_q, s1_d, s2_q, s2_d, data_q, data_d, flip;
    logic [PW-1:0]            presc_q, presc_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic                     changed_q, changed_d, tick;
    always_comb begin
        s1_d = raw_in;
        s2_d = s1_q;
        tick = presc_q == PW'(TICK_DIV - 1);
        presc_d = tick ? '0 : presc_q + PW'(1);
        data_d = data_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (s2_q[i] == data_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                    data_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        flip = data_d ^ data_q;
        changed_d = |flip;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= RESET_VALUE;
            s2_q      <= RESET_VALUE;
            data_q    <= RESET_VALUE;
            presc_q   <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            data_q    <= data_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end
    assign data_out = data_q;
    assign changed  = changed_q;
`ifdef EDGE_CAPTURE_EN
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             irq_q, irq_d;
    // a new flip overrides a simultaneous clear so no edge is ever lost
    always_comb begin
        edge_d = (edge_q & ~edge_clear) | flip;
        irq_d  = |edge_d;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end
    assign edge_capture = edge_q;
    assign irq          = irq_q;
`endif
endmodule

// File: tb/tb_pio_input_debouncer.sv
// tb_pio_input_debouncer: directed and randomized checks of pio_input_debouncer against a behavioural model
module tb_pio_input_debouncer;
    localparam int W  = 14;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam logic [W-1:0] RV = '0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw_in = 14'h3FFF;
    logic [W-1:0] data_out;
    logic         changed;
`ifdef EDGE_CAPTURE_EN
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] edge_capture;
    logic         irq;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int lat;

    pio_input_debouncer #(
        .WIDTH(W), .TICK_DIV(TD), .DEBOUNCE_TICKS(DT), .RESET_VALUE(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .data_out(data_out),
`ifdef EDGE_CAPTURE_EN
        .changed(changed),
        .edge_clear(edge_clear),
        .edge_capture(edge_capture),
        .irq(irq)
`else
        .changed(changed)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the input reaches the filter two clocks late; every TD-th clock after reset
    // is a sample; a bit is accepted once DT samples in a row disagree with the output.
    logic [W-1:0] p1, p2, m_out, fl;
    logic         m_chg;
    int           k;
    int           run [W];
`ifdef EDGE_CAPTURE_EN
    logic [W-1:0] m_edge;
    logic         m_irq;
`endif

    always @(negedge clk) begin
        fl = '0;
        if (reset) begin
            p1 = RV; p2 = RV; m_out = RV; m_chg = 1'b0; k = 0;
            for (int i = 0; i < W; i++) run[i] = 0;
`ifdef EDGE_CAPTURE_EN
            m_edge = '0; m_irq = 1'b0;
`endif
        end else begin
            if (k % TD == TD - 1)
                for (int i = 0; i < W; i++)
                    if (p2[i] != m_out[i]) begin
                        run[i]++;
                        if (run[i] == DT) begin fl[i] = 1'b1; run[i] = 0; end
                    end else run[i] = 0;
            m_out = m_out ^ fl;
            m_chg = |fl;
            p2 = p1;
            p1 = raw_in;
            k++;
`ifdef EDGE_CAPTURE_EN
            m_edge = (m_edge & ~edge_clear) | fl;
            m_irq = |m_edge;
`endif
        end
        chk("model_data_out", data_out, m_out);
        chk("model_changed", changed, m_chg);
`ifdef EDGE_CAPTURE_EN
        chk("model_edge_capture", edge_capture, m_edge);
        chk("model_irq", irq, m_irq);
`endif
        if (changed) pulses++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [W-1:0] v);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        raw_in = v;
        pulses = 0;
    endtask

    task automatic measure(input logic [W-1:0] mask, input logic [W-1:0] tgt, output int l);
        l = -1;
        for (int i = 1; i <= 100 && l < 0; i++) begin
            step();
            if ((data_out & mask) == tgt) l = i;
        end
    endtask

    initial begin
        step();
        step();
        chk("reset_data_out", data_out, 14'h0000);
        chk("reset_changed", changed, 1'b0);
`ifdef EDGE_CAPTURE_EN
        chk("reset_irq", irq, 1'b0);
`endif
        reset = 1'b0;
        raw_in = 14'h0001;
        pulses = 0;
        measure(14'h0001, 14'h0001, lat);
        chk("clean_latency", lat, 12);
        repeat (4) step();
        chk("clean_pulses", pulses, 1);
        chk("clean_level", data_out, 14'h0001);

        start(14'h0020);
        repeat (8) step();
        raw_in = 14'h0000;
        repeat (4) step();
        chk("bounce_not_yet", data_out, 14'h0000);
        chk("bounce_no_pulse", pulses, 0);
        raw_in = 14'h0020;
        measure(14'h0020, 14'h0020, lat);
        chk("bounce_latency", lat, 12);
        step();
        chk("bounce_pulses", pulses, 1);

        start(14'h2001);
        measure(14'h3FFF, 14'h2001, lat);
        chk("simul_rise_latency", lat, 12);
        chk("simul_rise_pulses", pulses, 1);
        raw_in = 14'h0000;
        pulses = 0;
        measure(14'h3FFF, 14'h0000, lat);
        chk("simul_fall_latency", lat, 12);
        repeat (2) step();
        chk("simul_fall_pulses", pulses, 1);

        start(14'h0008);
        repeat (8) step();
        reset = 1'b1;
        step();
        chk("midreset_data_out", data_out, 14'h0000);
        reset = 1'b0;
        measure(14'h0008, 14'h0008, lat);
        chk("midreset_latency", lat, 12);

`ifdef EDGE_CAPTURE_EN
        start(14'h0080);
        measure(14'h0080, 14'h0080, lat);
        chk("edge_latency", lat, 12);
        chk("edge_set", edge_capture, 14'h0080);
        chk("edge_irq_set", irq, 1'b1);
        edge_clear = 14'h0080;
        step();
        edge_clear = '0;
        chk("edge_cleared", edge_capture, 14'h0000);
        chk("edge_irq_cleared", irq, 1'b0);
        edge_clear = 14'h0080;
        raw_in = 14'h0000;
        measure(14'h0080, 14'h0000, lat);
        chk("edge_set_wins", edge_capture, 14'h0080);
        chk("edge_set_wins_irq", irq, 1'b1);
        step();
        edge_clear = '0;
        chk("edge_clear_after", edge_capture, 14'h0000);
`endif

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(399) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            if ($urandom_range(5) == 0) raw_in = raw_in ^ (W'(1) << $urandom_range(W - 1));
`ifdef EDGE_CAPTURE_EN
            edge_clear = ($urandom_range(3) == 0) ? W'($urandom) : '0;
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
